// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game flow, health, score/combo and prescaled game clock
// Optional high-score register enabled by GAME_STATE_HIGH_SCORE_EN.
module game_state_ctrl #(
  parameter int TICK_DIV     = 650000,
  parameter int GAME_LEN     = 6000,
  parameter int TIME_W       = 18,
  parameter int SCORE_W      = 12,
  parameter int HEALTH_MAX   = 8,
  parameter int COMBO_MAX    = 4,
  parameter int SLICE_POINTS = 1
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  input  logic                              block_sliced,
  input  logic                              block_missed,
  input  logic                              player_hit_by_obstacle,
  output logic [1:0]                        state,
  output logic [$clog2(HEALTH_MAX+1)-1:0]   health_out,
  output logic [SCORE_W-1:0]                score_out,
  output logic [$clog2(COMBO_MAX+1)-1:0]    combo_out,
  output logic [TIME_W-1:0]                 curr_time,
  output logic [TIME_W-1:0]                 max_time,
  output logic                              tick_out
`ifdef GAME_STATE_HIGH_SCORE_EN
  ,output logic [SCORE_W-1:0]               high_score_out
`endif
);

  localparam int HW   = $clog2(HEALTH_MAX + 1);
  localparam int HW1  = HW + 1;
  localparam int CW   = $clog2(COMBO_MAX + 1);
  localparam int PW   = $clog2(TICK_DIV);
  localparam int SUMW = SCORE_W + CW + 32;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    S_MENU    = 2'd0,
    S_PLAYING = 2'd1,
    S_WON     = 2'd2,
    S_LOST    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       health_q, health_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [CW-1:0]       combo_q, combo_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
`ifdef GAME_STATE_HIGH_SCORE_EN
  logic [SCORE_W-1:0]  high_q, high_d;
`endif

  logic                tick;
  logic [SUMW-1:0]     sum;
  logic [1:0]          loss;

  assign tick = (presc_q == PW'(TICK_DIV - 1));
  // Slice value uses the combo held before this edge's update.
  assign sum  = SUMW'(score_q) + SUMW'(combo_q) * SUMW'(SLICE_POINTS);
  assign loss = {1'b0, block_missed} + {1'b0, player_hit_by_obstacle};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= S_MENU;
      health_q <= HW'(HEALTH_MAX);
      score_q  <= '0;
      combo_q  <= CW'(1);
      time_q   <= '0;
      presc_q  <= '0;
      tick_q   <= 1'b0;
`ifdef GAME_STATE_HIGH_SCORE_EN
      high_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      score_q  <= score_d;
      combo_q  <= combo_d;
      time_q   <= time_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
`ifdef GAME_STATE_HIGH_SCORE_EN
      high_q   <= high_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    score_d  = score_q;
    combo_d  = combo_q;
    time_d   = time_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    case (state_q)
      S_MENU: begin
        if (start_in) begin
          state_d  = S_PLAYING;
          health_d = HW'(HEALTH_MAX);
          score_d  = '0;
          combo_d  = CW'(1);
          time_d   = '0;
          presc_d  = '0;
        end
      end
      S_PLAYING: begin
        tick_d  = tick;
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) time_d = time_q + 1'b1;
        if (block_sliced) begin
          score_d = (sum > SUMW'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
          combo_d = (combo_q >= CW'(COMBO_MAX)) ? CW'(COMBO_MAX) : combo_q + 1'b1;
        end
        if (loss != 2'd0) begin
          health_d = (HW1'(health_q) > HW1'(loss)) ? health_q - HW'(loss) : '0;
          combo_d  = CW'(1);
        end
        // Running out of health takes priority over the final tick.
        if (health_d == '0) state_d = S_LOST;
        else if (tick && time_d == TIME_W'(GAME_LEN)) state_d = S_WON;
      end
      default: begin
        if (start_in) begin
          state_d  = S_MENU;
          health_d = HW'(HEALTH_MAX);
          score_d  = '0;
          combo_d  = CW'(1);
          time_d   = '0;
          presc_d  = '0;
        end
      end
    endcase
  end

`ifdef GAME_STATE_HIGH_SCORE_EN
  always_comb begin
    high_d = high_q;
    if (state_q == S_PLAYING && state_d != S_PLAYING && score_d > high_q)
      high_d = score_d;
  end
  assign high_score_out = high_q;
`endif

  assign state      = state_q;
  assign health_out = health_q;
  assign score_out  = score_q;
  assign combo_out  = combo_q;
  assign curr_time  = time_q;
  assign max_time   = TIME_W'(GAME_LEN);
  assign tick_out   = tick_q;

endmodule
